// File: rtl/carry_and_pkg.sv
// Shared constants and elaboration-time helpers for the wide AND-reduction.
package carry_and_pkg;

    // Implementation style encodings for the METHOD parameter.
    localparam int CA_BEHAV = 0;
    localparam int CA_ADDER = 1;
    localparam int CA_EQ    = 2;
    localparam int CA_TREE  = 3;
    localparam int CA_CHAIN = 4;

    // Number of bits present at a given tree level (level 0 is the input vector).
    function automatic int ca_level_width(input int width, input int lvl);
        int n;
        n = width;
        for (int i = 0; i < lvl; i++) begin
            n = (n + 3) / 4;
        end
        return n;
    endfunction

    // Number of 4-input AND levels needed: ceil(log4(width)), 0 for width 1.
    function automatic int ca_tree_levels(input int width);
        int n;
        int l;
        n = width;
        l = 0;
        while (n > 1) begin
            n = (n + 3) / 4;
            l++;
        end
        return l;
    endfunction

    // Bit offset of a level inside the flattened node vector of the tree.
    function automatic int ca_level_offset(input int width, input int lvl);
        int s;
        s = 0;
        for (int i = 0; i < lvl; i++) begin
            s = s + ca_level_width(width, i);
        end
        return s;
    endfunction

endpackage

// File: rtl/carry_and_tree.sv
// Levelled 4-input AND tree. All levels live in one flat node vector so every
// node bit is driven exactly once and consumed exactly once.
module carry_and_tree
    import carry_and_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] i_dat,
    output logic             o_out
);

    localparam int LEVELS = ca_tree_levels(WIDTH);
    localparam int TOTAL  = ca_level_offset(WIDTH, LEVELS + 1);

    logic [TOTAL-1:0] w_node;

    assign w_node[WIDTH-1:0] = i_dat;

    // Each level ANDs groups of four nodes from the level below; the short
    // last group is padded with ones so it does not mask the result.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NIN  = ca_level_width(WIDTH, l);
        localparam int NOUT = ca_level_width(WIDTH, l + 1);
        localparam int IOFF = ca_level_offset(WIDTH, l);
        localparam int OOFF = ca_level_offset(WIDTH, l + 1);
        for (genvar g = 0; g < NOUT; g++) begin : g_grp
            logic [3:0] w_grp;
            for (genvar k = 0; k < 4; k++) begin : g_bit
                if (4 * g + k < NIN) begin : g_real
                    assign w_grp[k] = w_node[IOFF + 4 * g + k];
                end else begin : g_pad
                    assign w_grp[k] = 1'b1;
                end
            end
            assign w_node[OOFF + g] = &w_grp;
        end
    end

    // The final level is always a single bit sitting at the top of the vector.
    assign o_out = w_node[TOTAL-1];

endmodule

// File: rtl/carry_and.sv
// Wide AND-reduction with a selectable implementation style and a registered copy.
module carry_and
    import carry_and_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int METHOD = CA_BEHAV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dat,
    output logic             out,
    output logic             out_q
);

    logic w_out;
    logic r_out_q;

    if (METHOD == CA_ADDER) begin : g_adder
        // Adding one to an all-ones vector is the only way to carry out of the top.
        logic [WIDTH:0] w_sum;
        assign w_sum = {1'b0, dat} + {{WIDTH{1'b0}}, 1'b1};
        assign w_out = w_sum[WIDTH];
    end else if (METHOD == CA_EQ) begin : g_eq
        assign w_out = (dat == {WIDTH{1'b1}});
    end else if (METHOD == CA_TREE) begin : g_tree
        carry_and_tree #(
            .WIDTH (WIDTH)
        ) u_tree (
            .i_dat (dat),
            .o_out (w_out)
        );
    end else if (METHOD == CA_CHAIN) begin : g_chain
        // One mux per bit, written so the tool can map it onto a carry chain.
        logic [WIDTH:0] w_c;
        assign w_c[0] = 1'b1;
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage
            assign w_c[i + 1] = dat[i] ? w_c[i] : 1'b0;
        end
        assign w_out = w_c[WIDTH];
    end else begin : g_behav
        // CA_BEHAV, and the fallback for any unrecognised METHOD value.
        assign w_out = &dat;
    end

    // Registered copy of the reduction; reset clears only this register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q <= 1'b0;
        end else begin
            r_out_q <= w_out;
        end
    end

    assign out   = w_out;
    assign out_q = r_out_q;

endmodule

// File: tb/tb_carry_and.sv
// Scoreboard bench: 5 widths x 6 methods (0..4 plus invalid 7) on shared stimulus.
module tb_carry_and;

    localparam int NG = 5;
    localparam int NM = 6;

    function automatic int wid(input int g);
        case (g)
            0:       return 10;
            1:       return 1;
            2:       return 5;
            3:       return 16;
            default: return 17;
        endcase
    endfunction

    function automatic int meth(input int m);
        return (m == 5) ? 7 : m;
    endfunction

    typedef struct {
        logic [NG-1:0] e_out;
        logic [NG-1:0] e_q;
        bit            q_valid;
    } item_t;

    logic        clk;
    logic        rst;
    logic [16:0] dv  [NG];
    logic [16:0] nxt [NG];
    logic        o   [NG][NM];
    logic        q   [NG][NM];

    item_t sb[$];
    int    total;
    int    passed;

    bit            have_prev;
    bit            prev_rst;
    logic [NG-1:0] prev_ones;

    for (genvar g = 0; g < NG; g++) begin : g_w
        localparam int W = wid(g);
        for (genvar m = 0; m < NM; m++) begin : g_m
            carry_and #(
                .WIDTH  (W),
                .METHOD (meth(m))
            ) u_dut (
                .clk   (clk),
                .rst   (rst),
                .dat   (dv[g][W-1:0]),
                .out   (o[g][m]),
                .out_q (q[g][m])
            );
        end
    end

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Apply nxt for one cycle and queue the response the reference expects.
    task automatic step(input bit r);
        item_t it;
        logic [16:0] mk;
        @(posedge clk);
        #1;
        rst = r;
        for (int g = 0; g < NG; g++) begin
            mk = 17'((33'h1 << wid(g)) - 33'h1);
            dv[g] = nxt[g] & mk;
        end
        for (int g = 0; g < NG; g++) begin
            it.e_out[g] = ($countones(dv[g]) == wid(g));
            it.e_q[g]   = prev_rst ? 1'b0 : prev_ones[g];
        end
        it.q_valid = have_prev;
        sb.push_back(it);
        have_prev = 1'b1;
        prev_rst  = r;
        prev_ones = it.e_out;
    endtask

    task automatic set_all(input logic [16:0] v);
        for (int g = 0; g < NG; g++) nxt[g] = v;
    endtask

    // Monitor: compare every instance whenever an expected response is pending.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                it = sb.pop_front();
                for (int g = 0; g < NG; g++) begin
                    for (int m = 0; m < NM; m++) begin
                        total++;
                        if (o[g][m] !== it.e_out[g])
                            $display("FAIL out w%0d method%0d dat=%h got %b expected %b",
                                     wid(g), meth(m), dv[g], o[g][m], it.e_out[g]);
                        else
                            passed++;
                        if (it.q_valid) begin
                            total++;
                            if (q[g][m] !== it.e_q[g])
                                $display("FAIL out_q w%0d method%0d got %b expected %b",
                                         wid(g), meth(m), q[g][m], it.e_q[g]);
                            else
                                passed++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        total     = 0;
        passed    = 0;
        have_prev = 1'b0;
        prev_rst  = 1'b0;
        prev_ones = '0;
        rst       = 1'b1;
        for (int g = 0; g < NG; g++) dv[g] = '0;

        // Reset held with all ones, release, drop a bit, then reset mid-stream.
        set_all('1);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        nxt[0] = 17'h3FD;
        step(1'b0);
        set_all('1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b0);

        set_all('0);
        step(1'b0);

        // Walking zero on every width (10'h3FB among them for the invalid method).
        for (int i = 0; i < 17; i++) begin
            for (int g = 0; g < NG; g++) nxt[g] = ~(17'h1 << (i % wid(g)));
            step(1'b0);
        end

        set_all('1);
        step(1'b0);

        for (int n = 0; n < 1000; n++) begin
            for (int g = 0; g < NG; g++) begin
                r = $urandom_range(0, 3);
                if (r == 0)      nxt[g] = '1;
                else if (r == 1) nxt[g] = ~(17'h1 << $urandom_range(0, 16));
                else             nxt[g] = 17'($urandom);
            end
            if (n % 50 == 0) set_all('1);
            step($urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0)
            $display("FAIL drain got %0d pending expected 0", sb.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
